tdm_rx_pingpong: RTL and testbench
==================================

Name: tdm_rx_pingpong

Overview:
- Parametrised successor to the ST-bus serial capture path.
- Oversamples the TDM link (f0 frame sync, c4 bit clock at C4_PER_BIT × bit rate, data_from_dt) in the clk50 domain and packs BITS_PER_FRAME bits per frame into a ping-pong buffer of FRAMES_PER_BUF frames.
- When a buffer fills, it raises cpu_int. The STM then drains the filled buffer serially with clk_from_stm while the other half keeps filling.

Parameters:
- BITS_PER_FRAME, 32: bits captured per frame (≥1).
- FRAMES_PER_BUF, 16: frames per buffer half (≥1).
- C4_PER_BIT, 2: c4 rising edges per data bit; sample on the first edge of each group.
- SYNC_STAGES, 2: synchroniser depth for all asynchronous inputs (≥2).

Ports:
- clk50, in, 1: system clock; all logic is on its rising edge.
- reset_in_rg, in, 1: synchronous, active-high reset.
- f0, in, 1: frame sync, active low, async.
- c4, in, 1: TDM bit clock, async.
- data_from_dt, in, 1: TDM serial data, async.
- clk_from_stm, in, 1: readout shift clock from STM, async.
- data_to_stm, out, 1: serial readout data.
- cpu_int, out, 1: buffer-ready level.
- ready_buf, out, 1: index (0/1) of the buffer being read out.
- overrun, out, 1: sticky; a buffer completed before the previous one was drained.
- frame_err, out, 1: sticky frame-length error (optional feature).

Behaviour:
- Reset values: data_to_stm=0, cpu_int=0, ready_buf=0, overrun=0, frame_err=0. Internal state after reset: write buffer 0, bit/frame/c4 counters 0, rd_ptr 0. Buffer contents are not cleared.
- Synchronisation:
  - f0, c4 and data_from_dt pass through identical SYNC_STAGES flop chains, so they stay mutually aligned.
  - clk_from_stm has its own chain.
  - Rising edges are detected with one extra flop.
  - c4 and clk_from_stm high and low phases must each be ≥ SYNC_STAGES+1 clk50 periods.
- Capture, on each detected c4 rising edge:
  - f0_s==0: c4 counter and bit counter go to 0; no sample taken.
  - f0_s==1 and c4 counter==0 and bit counter<BITS_PER_FRAME: write data_s into wbuf[frame*BITS_PER_FRAME+bit], then bit counter +1.
  - c4 counter increments and wraps at C4_PER_BIT.
  - Bits beyond BITS_PER_FRAME before the next f0 low are ignored.
- Frame complete:
  - Triggered on the edge that stores bit BITS_PER_FRAME-1. The frame counter increments.
  - If this is frame FRAMES_PER_BUF-1: frame counter→0, toggle the write buffer, ready_buf←buffer just filled, rd_ptr←0, cpu_int←1.
  - If cpu_int was already 1 at that swap, overrun←1.
- Readout, on each detected clk_from_stm rising edge:
  - data_to_stm←rbuf[rd_ptr], then rd_ptr+1. Bit order is LSB (index 0) first.
  - When rd_ptr reaches FRAMES_PER_BUF*BITS_PER_FRAME-1 and that bit is shifted: rd_ptr→0, cpu_int←0.
  - Edges while cpu_int==0 still shift out ready_buf data and wrap, with no effect on cpu_int.
- Simultaneous events: a swap and a read edge in the same cycle resolve in favour of the swap. The read edge is discarded; data_to_stm holds its value.
- reset_in_rg mid-frame or mid-readout aborts both immediately. The next capture starts at the first f0 low.
- Latency:
  - data_to_stm updates SYNC_STAGES+2 clk50 cycles after a clk_from_stm rising edge.
  - cpu_int rises SYNC_STAGES+2 cycles after the c4 edge that carried the last bit.
- Widths: counters are sized with $clog2 of their terminal counts. The buffer is 2×FRAMES_PER_BUF×BITS_PER_FRAME bits.

Optional Feature:
- Macro: TDM_FRAME_CHECK_EN.
- Defined: on each f0_s falling edge (excluding the first after reset), if the bit counter ≠ BITS_PER_FRAME, frame_err←1 (sticky) and the partial frame is discarded (frame counter unchanged).
- Undefined: frame_err tied 0; short frames leave their partial bits in place and are overwritten by the next frame in the same slot.

Test Plan:
- Reset, then 16 frames of 32 bits with pattern bit=i[0]^frame[0], C4_PER_BIT=2 → cpu_int=1, ready_buf=0, overrun=0.
- After the first fill, 512 clk_from_stm pulses → data_to_stm reproduces the captured bits in index order; cpu_int falls after the 512th pulse.
- Fill buffer 0 and do not read, then fill buffer 1 → overrun=1, ready_buf=1, rd_ptr restarts; the first readout bit equals buffer 1 bit 0.
- Frame with 40 bits between f0 lows → bits 32..39 ignored, frame counter +1 only.
- With TDM_FRAME_CHECK_EN, a 20-bit frame → frame_err=1, frame counter unchanged. Without the macro → frame_err stays 0.
- Assert reset_in_rg at bit 10 of frame 5 → all outputs return to reset values; the next full 16 frames set cpu_int with ready_buf=0.

Source files
------------

// File: rtl/tdm_rx_pingpong_if.sv
// TDM link and STM readout signals of the ping-pong receiver.
// master: link/STM driver side, slave: the receiver.
interface tdm_rx_pingpong_if;
    logic f0;
    logic c4;
    logic data_from_dt;
    logic clk_from_stm;
    logic data_to_stm;
    logic cpu_int;
    logic ready_buf;
    logic overrun;
    logic frame_err;

    modport master (
        output f0, c4, data_from_dt, clk_from_stm,
        input  data_to_stm, cpu_int, ready_buf, overrun, frame_err
    );

    modport slave (
        input  f0, c4, data_from_dt, clk_from_stm,
        output data_to_stm, cpu_int, ready_buf, overrun, frame_err
    );
endinterface

// File: rtl/tdm_rx_pingpong.sv
// TDM receive path: oversamples f0/c4/data in the clk50 domain, packs
// BITS_PER_FRAME bits per frame into one half of a ping-pong buffer and
// hands full halves to the STM, which shifts them out with clk_from_stm.
// Optional macro TDM_FRAME_CHECK_EN enables the sticky frame-length check.
module tdm_rx_pingpong #(
    parameter int BITS_PER_FRAME = 32,
    parameter int FRAMES_PER_BUF = 16,
    parameter int C4_PER_BIT     = 2,
    parameter int SYNC_STAGES    = 2
) (
    input logic              clk50,
    input logic              reset_in_rg,
    tdm_rx_pingpong_if.slave tdm
);
    localparam int BUF_BITS = FRAMES_PER_BUF * BITS_PER_FRAME;
    localparam int RD_W     = (BUF_BITS > 1) ? $clog2(BUF_BITS) : 1;
    localparam int FC_W     = (FRAMES_PER_BUF > 1) ? $clog2(FRAMES_PER_BUF) : 1;
    localparam int C4_W     = (C4_PER_BIT > 1) ? $clog2(C4_PER_BIT) : 1;
    localparam int BC_W     = $clog2(BITS_PER_FRAME + 1);

    // {f0, c4, data} share one chain so they stay mutually aligned
    logic [SYNC_STAGES-1:0][2:0] link_sync;
    logic [SYNC_STAGES-1:0]      stm_sync;
    logic                        f0_s, c4_s, data_s, stm_s;
    logic                        c4_d, stm_d;
    logic                        c4_rise_q, stm_rise_q, f0_q, data_q;

    logic [C4_W-1:0]             c4_cnt;
    logic [BC_W-1:0]             bit_cnt;
    logic [FC_W-1:0]             frame_cnt;
    logic [RD_W-1:0]             rd_ptr;
    logic                        wsel;
    logic                        armed;
    logic                        data_to_stm_q, cpu_int_q, ready_buf_q, overrun_q;
    logic [1:0][BUF_BITS-1:0]    buf_q;

    logic                        cap_wr, frame_done, swap;
    logic [RD_W-1:0]             waddr;

    assign f0_s   = link_sync[SYNC_STAGES-1][2];
    assign c4_s   = link_sync[SYNC_STAGES-1][1];
    assign data_s = link_sync[SYNC_STAGES-1][0];
    assign stm_s  = stm_sync[SYNC_STAGES-1];

    // Synchronisers plus registered rising-edge events with aligned f0/data
    always_ff @(posedge clk50) begin
        if (reset_in_rg) begin
            link_sync  <= '0;
            stm_sync   <= '0;
            c4_d       <= 1'b0;
            stm_d      <= 1'b0;
            c4_rise_q  <= 1'b0;
            stm_rise_q <= 1'b0;
            f0_q       <= 1'b0;
            data_q     <= 1'b0;
        end else begin
            link_sync  <= {link_sync[SYNC_STAGES-2:0], {tdm.f0, tdm.c4, tdm.data_from_dt}};
            stm_sync   <= {stm_sync[SYNC_STAGES-2:0], tdm.clk_from_stm};
            c4_d       <= c4_s;
            stm_d      <= stm_s;
            c4_rise_q  <= c4_s & ~c4_d;
            stm_rise_q <= stm_s & ~stm_d;
            f0_q       <= f0_s;
            data_q     <= data_s;
        end
    end

    // Capture qualification; nothing is stored until an f0 low has been seen
    always_comb begin
        cap_wr     = c4_rise_q && f0_q && armed && (c4_cnt == '0) &&
                     (bit_cnt < BC_W'(BITS_PER_FRAME));
        frame_done = cap_wr && (bit_cnt == BC_W'(BITS_PER_FRAME - 1));
        swap       = frame_done && (frame_cnt == FC_W'(FRAMES_PER_BUF - 1));
        waddr      = RD_W'(frame_cnt) * RD_W'(BITS_PER_FRAME) + RD_W'(bit_cnt);
    end

    // Buffer storage survives reset; only writes are suppressed during it
    always_ff @(posedge clk50) begin
        if (!reset_in_rg && cap_wr)
            buf_q[wsel][waddr] <= data_q;
    end

    // Capture counters, buffer swap and STM readout; swap beats a read edge
    always_ff @(posedge clk50) begin
        if (reset_in_rg) begin
            c4_cnt        <= '0;
            bit_cnt       <= '0;
            frame_cnt     <= '0;
            rd_ptr        <= '0;
            wsel          <= 1'b0;
            armed         <= 1'b0;
            data_to_stm_q <= 1'b0;
            cpu_int_q     <= 1'b0;
            ready_buf_q   <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            if (c4_rise_q) begin
                if (!f0_q) begin
                    c4_cnt  <= '0;
                    bit_cnt <= '0;
                    armed   <= 1'b1;
                end else begin
                    c4_cnt <= (c4_cnt == C4_W'(C4_PER_BIT - 1)) ? '0 : c4_cnt + C4_W'(1);
                    if (cap_wr)
                        bit_cnt <= bit_cnt + BC_W'(1);
                end
            end
            if (frame_done)
                frame_cnt <= swap ? '0 : frame_cnt + FC_W'(1);
            if (swap) begin
                wsel        <= ~wsel;
                ready_buf_q <= wsel;
                rd_ptr      <= '0;
                cpu_int_q   <= 1'b1;
                if (cpu_int_q)
                    overrun_q <= 1'b1;
            end else if (stm_rise_q) begin
                data_to_stm_q <= buf_q[ready_buf_q][rd_ptr];
                if (rd_ptr == RD_W'(BUF_BITS - 1)) begin
                    rd_ptr    <= '0;
                    cpu_int_q <= 1'b0;
                end else begin
                    rd_ptr <= rd_ptr + RD_W'(1);
                end
            end
        end
    end

    assign tdm.data_to_stm = data_to_stm_q;
    assign tdm.cpu_int     = cpu_int_q;
    assign tdm.ready_buf   = ready_buf_q;
    assign tdm.overrun     = overrun_q;

`ifdef TDM_FRAME_CHECK_EN
    logic f0_d, f0_fall_q, frame_err_q;

    // Flag frames whose bit count was short when the next f0 low arrives
    always_ff @(posedge clk50) begin
        if (reset_in_rg) begin
            f0_d        <= 1'b0;
            f0_fall_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            f0_d      <= f0_s;
            f0_fall_q <= f0_d & ~f0_s;
            if (f0_fall_q && armed && (bit_cnt != BC_W'(BITS_PER_FRAME)))
                frame_err_q <= 1'b1;
        end
    end

    assign tdm.frame_err = frame_err_q;
`else
    assign tdm.frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_rx_pingpong.sv
// Directed/random bench for tdm_rx_pingpong with a frame-level reference model.
module tb_tdm_rx_pingpong;
    localparam int BPF = 32;
    localparam int FPB = 16;
    localparam int C4B = 2;
    localparam int NB  = BPF * FPB;
`ifdef TDM_FRAME_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk50 = 1'b0;
    logic reset_in_rg = 1'b1;

    tdm_rx_pingpong_if tif();

    tdm_rx_pingpong #(
        .BITS_PER_FRAME(BPF),
        .FRAMES_PER_BUF(FPB),
        .C4_PER_BIT(C4B),
        .SYNC_STAGES(2)
    ) dut (
        .clk50(clk50),
        .reset_in_rg(reset_in_rg),
        .tdm(tif)
    );

    always #5 clk50 = ~clk50;

    int checks = 0;
    int errors = 0;

    // reference model: buffer halves and frame-level bookkeeping
    bit mbuf [2][NB];
    int m_wb, m_frame, m_ready, m_rd, m_prev;
    bit m_cpu, m_ovr, m_err, m_armed;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk50);
    endtask

    task automatic c4_pulse();
        tif.c4 = 1'b1;
        wait_n(3);
        tif.c4 = 1'b0;
        wait_n(3);
    endtask

    task automatic model_reset();
        m_wb = 0; m_frame = 0; m_ready = 0; m_rd = 0; m_prev = BPF;
        m_cpu = 1'b0; m_ovr = 1'b0; m_err = 1'b0; m_armed = 1'b0;
    endtask

    // one frame: optional f0 low, then nbits data bits of C4B c4 edges each
    task automatic send_frame(input int nbits, input bit patterned, input bit with_f0);
        bit b;
        if (with_f0) begin
            if (CHK && m_armed && m_prev < BPF) m_err = 1'b1;
            m_armed = 1'b1;
            tif.f0 = 1'b0;
            c4_pulse();
            tif.f0 = 1'b1;
        end
        for (int i = 0; i < nbits; i++) begin
            b = patterned ? 1'(i[0] ^ m_frame[0]) : 1'($urandom_range(0, 1));
            if (m_armed && i < BPF) mbuf[m_wb][m_frame * BPF + i] = b;
            tif.data_from_dt = b;
            for (int k = 0; k < C4B; k++) c4_pulse();
        end
        if (m_armed) begin
            m_prev = nbits;
            if (nbits >= BPF) begin
                m_frame++;
                if (m_frame == FPB) begin
                    m_frame = 0;
                    if (m_cpu) m_ovr = 1'b1;
                    m_ready = m_wb;
                    m_wb    = 1 - m_wb;
                    m_rd    = 0;
                    m_cpu   = 1'b1;
                end
            end
        end
    endtask

    task automatic send_frames(input int n, input bit patterned);
        for (int f = 0; f < n; f++) send_frame(BPF, patterned, 1'b1);
    endtask

    task automatic read_bit(input string tag);
        bit exp;
        exp = mbuf[m_ready][m_rd];
        m_rd++;
        if (m_rd == NB) begin
            m_rd  = 0;
            m_cpu = 1'b0;
        end
        tif.clk_from_stm = 1'b1;
        wait_n(5);
        check({tag, "_data"}, tif.data_to_stm, exp);
        check({tag, "_cpu"}, tif.cpu_int, m_cpu);
        tif.clk_from_stm = 1'b0;
        wait_n(3);
    endtask

    task automatic read_bits(input int n, input string tag);
        for (int i = 0; i < n; i++) read_bit(tag);
    endtask

    task automatic check_status(input string tag);
        check({tag, "_cpu_int"}, tif.cpu_int, m_cpu);
        check({tag, "_ready_buf"}, tif.ready_buf, 32'(m_ready));
        check({tag, "_overrun"}, tif.overrun, m_ovr);
        check({tag, "_frame_err"}, tif.frame_err, m_err);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tif.f0 = 1'b1;
        tif.c4 = 1'b0;
        tif.data_from_dt = 1'b0;
        tif.clk_from_stm = 1'b0;
        model_reset();
        reset_in_rg = 1'b1;
        wait_n(5);
        reset_in_rg = 1'b0;
        wait_n(2);
        check("rst_data_to_stm", tif.data_to_stm, 0);
        check_status("rst");

        // first fill with the alternating pattern; no interrupt one frame early
        send_frames(FPB - 1, 1'b1);
        check("fill0_early_cpu", tif.cpu_int, m_cpu);
        send_frame(BPF, 1'b1, 1'b1);
        check_status("fill0");

        // full drain of buffer 0; cpu_int falls on the last bit
        read_bits(NB, "drain0");

        // random fill of buffer 1, partial read, then overrun by buffer 0
        send_frames(FPB, 1'b0);
        check_status("fill1");
        read_bits(7, "part1");
        send_frames(FPB, 1'b0);
        check_status("ovr0");
        read_bits(3, "ovr0_rd");
        send_frames(FPB, 1'b0);
        check_status("ovr1");
        read_bits(3, "ovr1_rd");

        // long frame counts once; short frame is replaced in its slot
        send_frame(40, 1'b0, 1'b1);
        send_frames(FPB - 2, 1'b0);
        check("long_pre_ready", tif.ready_buf, 32'(m_ready));
        send_frame(20, 1'b0, 1'b1);
        send_frame(BPF, 1'b0, 1'b1);
        check_status("long_short");
        read_bits(NB, "long_rd");

        // reset at bit 10 of frame 5, trailing bits of that frame are ignored
        send_frames(5, 1'b0);
        send_frame(10, 1'b0, 1'b1);
        reset_in_rg = 1'b1;
        wait_n(4);
        reset_in_rg = 1'b0;
        model_reset();
        wait_n(2);
        check("midrst_data_to_stm", tif.data_to_stm, 0);
        check_status("midrst");
        send_frame(BPF - 10, 1'b0, 1'b0);
        send_frames(FPB, 1'b0);
        check_status("post_rst");
        read_bits(32, "post_rst_rd");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
